// File: rtl/countdown_display_pkg.sv
// Shared types and constants for the countdown display: segment table and alarm states.
package countdown_display_pkg;

  // Active-low segment patterns, bit order g..a.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic {IDLE, RING} alarm_state_t;

endpackage

// File: rtl/countdown_display_if.sv
// Bundle between the countdown source and the multiplexed display driver.
interface countdown_display_if;
  import countdown_display_pkg::*;

  logic       cnt_en;
  logic       load;
  logic [7:0] xq;
  logic [7:0] xh;
  logic [3:0] an;
  logic [7:0] seg;
  logic       alarm;

  modport master (output cnt_en, load, xq, xh, input an, seg, alarm);
  modport slave  (input cnt_en, load, xq, xh, output an, seg, alarm);

endinterface

// File: rtl/countdown_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes blank the digit.
module seg7_decode
  import countdown_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_LUT[bcd];
  end

endmodule

// File: rtl/countdown_display.sv
// Four-digit MM:SS multiplexed display driver with blinking colon and a
// timed alarm that fires when the countdown reaches 00:00.
//
// state | meaning
// IDLE  | no alarm; waiting for a rising edge of the zero flag while running
// RING  | alarm active; counts down half-second phases, display blinks
module countdown_display
  import countdown_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int HALF_DIV     = 25000000,
  parameter int ALARM_HALVES = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  countdown_display_if.slave bus
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int HALF_W = $clog2(HALF_DIV);
  localparam int REM_W  = $clog2(ALARM_HALVES + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_DIV - 1);
  localparam logic [REM_W-1:0]  REM_INIT  = REM_W'(ALARM_HALVES);

  logic [SCAN_W-1:0] scan_cnt;
  logic [HALF_W-1:0] half_cnt;
  logic [1:0]        digit_idx;
  logic              phase;
  logic              scan_tick;
  logic              half_tick;
  logic              zero;
  logic              zero_d;
  alarm_state_t      state;
  alarm_state_t      state_next;
  logic [REM_W-1:0]  remaining;
  logic [REM_W-1:0]  remaining_next;
  logic [3:0]        digit;
  logic [6:0]        seg_raw;
  logic              dp_lit;
  logic [3:0]        an_next;

  assign scan_tick = (scan_cnt == SCAN_LAST);
  assign half_tick = (half_cnt == HALF_LAST);
  assign zero      = (bus.xq == 8'h00) && (bus.xh == 8'h00);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      half_cnt  <= '0;
      phase     <= 1'b0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
      half_cnt <= half_tick ? '0 : half_cnt + HALF_W'(1);
      if (scan_tick) digit_idx <= digit_idx + 2'd1;
      if (half_tick) phase <= ~phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      zero_d    <= 1'b1;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      zero_d    <= zero;
    end
  end

  // A load in the same cycle as the zero edge suppresses the trigger.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    case (state)
      IDLE: begin
        if (zero && !zero_d && bus.cnt_en && !bus.load) begin
          state_next     = RING;
          remaining_next = REM_INIT;
        end
      end
      RING: begin
        if (bus.load) begin
          state_next     = IDLE;
          remaining_next = '0;
        end else if (half_tick) begin
          if (remaining <= REM_W'(1)) begin
            state_next     = IDLE;
            remaining_next = '0;
          end else begin
            remaining_next = remaining - REM_W'(1);
          end
        end
      end
      default: begin
        state_next     = IDLE;
        remaining_next = '0;
      end
    endcase
  end

  always_comb begin
    digit = bus.xh[3:0];
    case (digit_idx)
      2'd3:    digit = bus.xq[7:4];
      2'd2:    digit = bus.xq[3:0];
      2'd1:    digit = bus.xh[7:4];
      default: digit = bus.xh[3:0];
    endcase
  end

  seg7_decode u_seg7 (
    .bcd (digit),
    .seg (seg_raw)
  );

  assign dp_lit = (digit_idx == 2'd2) && (phase || !bus.cnt_en);

  // Scan keeps running while the alarm blanks the enables.
  always_comb begin
    an_next = 4'hF;
    if (!((state == RING) && !phase)) an_next[digit_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      bus.an  <= 4'hF;
      bus.seg <= 8'hFF;
    end else begin
      bus.an  <= an_next;
      bus.seg <= {~dp_lit, seg_raw};
    end
  end

  assign bus.alarm = (state == RING);

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display with a fast scan/half-second divider.
module tb_countdown_display;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  countdown_display_if bus();

  countdown_display #(
    .SCAN_DIV     (4),
    .HALF_DIV     (16),
    .ALARM_HALVES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for 3 edges and releases it at a falling edge; the next
  // rising edge is edge 1, sampled at the following falling edge as n=1.
  task automatic do_reset(input logic [7:0] q, input logic [7:0] h, input logic en);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.xq     = q;
    bus.xh     = h;
    bus.cnt_en = en;
    bus.load   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.an !== 4'hF) begin
      failures++;
      $display("FAIL reset_an got=%h exp=F", bus.an);
    end
    checks++;
    if (bus.seg !== 8'hFF) begin
      failures++;
      $display("FAIL reset_seg got=%h exp=FF", bus.seg);
    end
    checks++;
    if (bus.alarm !== 1'b0) begin
      failures++;
      $display("FAIL reset_alarm got=%b exp=0", bus.alarm);
    end
  endtask

  task automatic test_scan();
    logic [3:0] an_exp  [4];
    logic [7:0] seg_exp [4];
    an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    do_reset(8'h12, 8'h34, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      checks++;
      if (bus.an !== an_exp[(n-1)/4]) begin
        failures++;
        $display("FAIL scan_an n=%0d got=%h exp=%h", n, bus.an, an_exp[(n-1)/4]);
      end
      checks++;
      if (bus.seg !== seg_exp[(n-1)/4]) begin
        failures++;
        $display("FAIL scan_seg n=%0d got=%h exp=%h", n, bus.seg, seg_exp[(n-1)/4]);
      end
    end
  endtask

  task automatic test_colon();
    do_reset(8'h12, 8'h34, 1'b1);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 10 || n == 26 || n == 42 || n == 74) begin
        checks++;
        if (bus.an !== 4'hB) begin
          failures++;
          $display("FAIL colon_an n=%0d got=%h exp=B", n, bus.an);
        end
      end
      if (n == 10 || n == 42) begin
        checks++;
        if (bus.seg !== 8'hA4) begin
          failures++;
          $display("FAIL colon_off n=%0d got=%h exp=A4", n, bus.seg);
        end
      end
      if (n == 26 || n == 74) begin
        checks++;
        if (bus.seg !== 8'h24) begin
          failures++;
          $display("FAIL colon_on n=%0d got=%h exp=24", n, bus.seg);
        end
      end
      if (n == 60) bus.cnt_en = 1'b0;
    end
  endtask

  task automatic test_invalid_bcd();
    logic [7:0] seg_exp [4];
    seg_exp = '{8'hFF, 8'hB0, 8'hA4, 8'hF9};
    do_reset(8'h12, 8'h3C, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n % 4 == 2) begin
        checks++;
        if (bus.seg !== seg_exp[(n-1)/4]) begin
          failures++;
          $display("FAIL invalid_seg n=%0d got=%h exp=%h", n, bus.seg, seg_exp[(n-1)/4]);
        end
      end
    end
  endtask

  task automatic test_alarm_timeout();
    int highs;
    highs = 0;
    do_reset(8'h00, 8'h01, 1'b1);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      case (n)
        20: begin
          checks++;
          if (bus.alarm !== 1'b0) begin
            failures++;
            $display("FAIL alarm_early n=%0d got=%b exp=0", n, bus.alarm);
          end
          bus.xh = 8'h00;
        end
        21, 79: begin
          checks++;
          if (bus.alarm !== 1'b1) begin
            failures++;
            $display("FAIL alarm_on n=%0d got=%b exp=1", n, bus.alarm);
          end
        end
        80: begin
          checks++;
          if (bus.alarm !== 1'b0) begin
            failures++;
            $display("FAIL alarm_off n=%0d got=%b exp=0", n, bus.alarm);
          end
        end
        30: begin
          checks++;
          if (bus.an !== 4'h7) begin
            failures++;
            $display("FAIL ring_an_ph1 n=%0d got=%h exp=7", n, bus.an);
          end
        end
        56: begin
          checks++;
          if (bus.an !== 4'hD) begin
            failures++;
            $display("FAIL ring_an_ph1 n=%0d got=%h exp=D", n, bus.an);
          end
        end
        40, 70: begin
          checks++;
          if (bus.an !== 4'hF) begin
            failures++;
            $display("FAIL ring_blank n=%0d got=%h exp=F", n, bus.an);
          end
        end
        default: ;
      endcase
      if (n > 80 && bus.alarm) highs++;
    end
    checks++;
    if (highs !== 0) begin
      failures++;
      $display("FAIL alarm_retrigger high_cycles=%0d exp=0", highs);
    end
  endtask

  task automatic test_load_clear();
    int highs;
    highs = 0;
    do_reset(8'h00, 8'h01, 1'b1);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 5) bus.xh = 8'h00;
      if (n == 8) begin
        checks++;
        if (bus.alarm !== 1'b1) begin
          failures++;
          $display("FAIL load_pre n=%0d got=%b exp=1", n, bus.alarm);
        end
        bus.load = 1'b1;
      end
      if (n == 9) begin
        checks++;
        if (bus.alarm !== 1'b0) begin
          failures++;
          $display("FAIL load_clear n=%0d got=%b exp=0", n, bus.alarm);
        end
        bus.load = 1'b0;
      end
      if (n > 9 && n < 30 && bus.alarm) highs++;
      if (n == 30) bus.xh = 8'h01;
      if (n == 31) begin
        bus.xh   = 8'h00;
        bus.load = 1'b1;
      end
      if (n == 32 || n == 33 || n == 40) begin
        checks++;
        if (bus.alarm !== 1'b0) begin
          failures++;
          $display("FAIL load_wins n=%0d got=%b exp=0", n, bus.alarm);
        end
        bus.load = 1'b0;
      end
    end
    checks++;
    if (highs !== 0) begin
      failures++;
      $display("FAIL load_hold high_cycles=%0d exp=0", highs);
    end
  endtask

  task automatic test_reset_mid_ring();
    int highs;
    highs = 0;
    do_reset(8'h00, 8'h01, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 5) bus.xh = 8'h00;
    end
    checks++;
    if (bus.alarm !== 1'b1) begin
      failures++;
      $display("FAIL rst_ring_pre got=%b exp=1", bus.alarm);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.alarm !== 1'b0) begin
      failures++;
      $display("FAIL rst_ring_alarm got=%b exp=0", bus.alarm);
    end
    checks++;
    if (bus.an !== 4'hF || bus.seg !== 8'hFF) begin
      failures++;
      $display("FAIL rst_ring_disp an=%h seg=%h exp=F/FF", bus.an, bus.seg);
    end
    @(negedge clk);
    rst_n = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.alarm) highs++;
    end
    checks++;
    if (highs !== 0) begin
      failures++;
      $display("FAIL rst_release_alarm high_cycles=%0d exp=0", highs);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b1;
    bus.cnt_en = 1'b0;
    bus.load   = 1'b0;
    bus.xq     = 8'h00;
    bus.xh     = 8'h00;
    test_reset();
    test_scan();
    test_colon();
    test_invalid_bcd();
    test_alarm_timeout();
    test_load_clear();
    test_reset_mid_ring();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_display.md
COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range 2 or more.
REQ-002 Parameter HALF_DIV, default 25000000: clk cycles per half-second phase; legal range 2 or more.
REQ-003 Parameter ALARM_HALVES, default 10: half-second phases the alarm stays active.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous reset, active-high: sampled on clk, 1 = reset asserted.
REQ-006 cnt_en  input  1  countdown running; also gates the colon blink.
REQ-007 load  input  1  countdown reload strobe; clears an active alarm.
REQ-008 xq  input  8  minutes, packed BCD: [7:4] tens, [3:0] units.
REQ-009 xh  input  8  seconds, packed BCD: [7:4] tens, [3:0] units.
REQ-010 an  output  4  digit enables, active-low, one-hot-low; bit3 = minute tens, bit0 = second units.
REQ-011 seg  output  8  segments, active-low; [6:0] = g..a, [7] = dp.
REQ-012 alarm  output  1  high while the alarm is active.

Function
REQ-013 Scan counter: counts 0..SCAN_DIV-1, then wraps; the wrap cycle issues scan_tick.
REQ-014 digit index: 2 bits; advances 0->1->2->3->0 on each scan_tick.
REQ-015 an and seg: registered outputs; they reflect the current digit index one cycle after the index changes.
REQ-016 Digit sources: index 3 = xq[7:4], index 2 = xq[3:0], index 1 = xh[7:4], index 0 = xh[3:0].
REQ-017 Digit decode: BCD 0-9 gives standard 7-segment patterns; codes 10-15 blank the digit (seg[6:0] = 7'h7F).
REQ-018 Half counter: counts 0..HALF_DIV-1; each wrap toggles the phase bit.
REQ-019 Colon (dp): lit only on index 2; lit when phase = 1 and cnt_en = 1; steady lit when cnt_en = 0.
REQ-020 Zero detect: zero = (xq == 0) and (xh == 0); registered copy zero_d.
REQ-021 Alarm states: IDLE and RING.
REQ-022 IDLE -> RING: on cycle where zero = 1, zero_d = 0, and cnt_en = 1.
REQ-023 RING behaviour: on entry, load remaining = ALARM_HALVES; decrement remaining on each half counter wrap.
REQ-024 RING -> IDLE: when remaining reaches 0, or when load = 1.
REQ-025 Simultaneous load and zero edge: load wins; the state stays or returns to IDLE.
REQ-026 alarm output: alarm = 1 exactly while state = RING.
REQ-027 Display blanking in RING: when phase = 0, an = 4'hF; when phase = 1, display is normal.
REQ-028 Digit scan in RING: continues regardless of blanking.
REQ-029 Zero held at 00:00: no alarm re-trigger after timeout; a new trigger requires zero to fall and rise again.
REQ-030 Inputs xq, xh: used as sampled each cycle; no handshake; glitch-free as driven by the upstream counter.

Reset
REQ-031 While rst_n = 1: scan counter = 0, digit index = 0, half counter = 0, phase = 0.
REQ-032 While rst_n = 1: state = IDLE, remaining = 0, zero_d = 1.
REQ-033 Output reset values: an = 4'hF, seg = 8'hFF, alarm = 0.
REQ-034 Reset mid-RING: alarm drops on the next clk edge; no alarm fires on release even if the display shows 00:00.

Structure
REQ-035 Shared package: BCD-to-segment constant table, blank pattern 7'h7F, alarm state enum {IDLE, RING}.
REQ-036 Sub-module: one seg7_decode (combinational, 4-bit in, 7-bit out); all other logic stays in this module.

Verification
REQ-037 Test parameters: SCAN_DIV = 4, HALF_DIV = 16, ALARM_HALVES = 4; reset for 3 cycles -> an = F, seg = FF, alarm = 0.
REQ-038 Scan: xq = 8'h12, xh = 8'h34 -> an cycles E, D, B, 7 every 4 clk; seg = 0x99, 0xB0, 0xA4, 0xF9 (digits 4, 3, 2, 1; dp off except colon rule).
REQ-039 Colon: cnt_en = 1 -> dp on index 2 toggles every 16 clk; cnt_en = 0 -> steady lit.
REQ-040 Invalid BCD: xh = 8'h3C -> index 0 seg[6:0] = 7F; other digits unaffected.
REQ-041 Alarm timeout: 00:01 -> 00:00 with cnt_en = 1 -> alarm rises 1 cycle later, lasts 4 half-periods (about 64 clk) with an blanking on phase 0, then falls; holding 00:00 gives no re-trigger.
REQ-042 Alarm clear and reset: load pulse mid-RING -> alarm low next cycle; separately, rst_n = 1 mid-RING -> outputs return to reset values.
